inst_fetch_resp: RTL and testbench

- Responder end of the instruction-fetch interface. It accepts the fetch address and chip-enable from the program counter, obtains the 32-bit instruction from a wait-stated backing instruction memory, and returns it to the IF/ID boundary.
- Raises a stall request while a fetch is outstanding.
- Discards in-flight fetches on a branch flush.
- Reports misaligned fetches and memory timeouts.

---
 rtl/inst_fetch_resp.sv | 129 ++++++++++++
 tb/tb_inst_fetch_resp.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_resp.sv
// Instruction-fetch responder: serves PC fetches from a one-entry hit register
// or a wait-stated backing memory, with flush, misalign and timeout handling.
//
// state | meaning
// IDLE  | accepting fetches; hits and misaligned fetches are answered here
// WAIT  | miss outstanding on the memory bus, result will be delivered
// DRAIN | miss outstanding but flushed; the ack is absorbed silently
module inst_fetch_resp #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [31:0] addr,
  input  logic        flush,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] inst_addr,
  output logic        stall_req,
  output logic        misalign,
  output logic        bus_err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic [31:0] lat_addr;
  logic [31:0] hit_addr;
  logic [31:0] hit_inst;
  logic        hit_valid;
  logic        aligned;
  logic        hit;

  assign aligned   = (addr[1:0] == 2'b00);
  assign hit       = hit_valid && (addr == hit_addr);
  assign stall_req = (state != IDLE) || (ce && !flush && aligned && !hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      lat_addr   <= 32'd0;
      hit_addr   <= 32'd0;
      hit_inst   <= 32'd0;
      hit_valid  <= 1'b0;
      inst       <= NOP_INST;
      inst_addr  <= 32'd0;
      inst_valid <= 1'b0;
      misalign   <= 1'b0;
      bus_err    <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= 32'd0;
    end else begin
      inst_valid <= 1'b0;
      misalign   <= 1'b0;
      bus_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (!ce) begin
            hit_valid <= 1'b0;
          end else if (!flush) begin
            if (!aligned) begin
              inst       <= NOP_INST;
              inst_addr  <= addr;
              inst_valid <= 1'b1;
              misalign   <= 1'b1;
            end else if (hit) begin
              inst       <= hit_inst;
              inst_addr  <= addr;
              inst_valid <= 1'b1;
            end else begin
              mem_req  <= 1'b1;
              mem_addr <= {addr[31:2], 2'b00};
              lat_addr <= addr;
              cnt      <= 8'd0;
              state    <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= IDLE;
            if (!flush) begin
              inst       <= mem_rdata;
              inst_addr  <= lat_addr;
              inst_valid <= 1'b1;
              hit_addr   <= lat_addr;
              hit_inst   <= mem_rdata;
              hit_valid  <= 1'b1;
            end
          end else if (flush) begin
            // keep counting so a flushed fetch is still bounded by the timeout
            cnt   <= cnt + 8'd1;
            state <= DRAIN;
          end else if (cnt >= TO_LAST) begin
            inst       <= NOP_INST;
            inst_addr  <= lat_addr;
            inst_valid <= 1'b1;
            bus_err    <= 1'b1;
            mem_req    <= 1'b0;
            hit_valid  <= 1'b0;
            state      <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DRAIN: begin
          if (mem_ack || cnt >= TO_LAST) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Scoreboard bench for inst_fetch_resp: directed fetches push expected results,
// a negedge monitor pops and compares on every inst_valid pulse.
module tb_inst_fetch_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0;
  logic [31:0] addr = 32'd0;
  logic        flush = 1'b0;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] inst_addr;
  logic        stall_req;
  logic        misalign;
  logic        bus_err;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] a;
    logic        mis;
    logic        be;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  inst_fetch_resp #(.TIMEOUT(16), .NOP_INST(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .flush(flush),
    .inst(inst), .inst_valid(inst_valid), .inst_addr(inst_addr),
    .stall_req(stall_req), .misalign(misalign), .bus_err(bus_err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_resp(input logic [31:0] i, input logic [31:0] a,
                             input logic m, input logic b);
    exp_t e;
    e.inst = i; e.a = a; e.mis = m; e.be = b;
    q.push_back(e);
  endtask

  // monitor: every pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst) begin
      if (inst_valid) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pulse: inst=%h addr=%h, expected no pulse", inst, inst_addr);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (inst !== e.inst || inst_addr !== e.a || misalign !== e.mis || bus_err !== e.be) begin
            n_fail++;
            $display("FAIL resp: got inst=%h addr=%h mis=%b be=%b, expected inst=%h addr=%h mis=%b be=%b",
                     inst, inst_addr, misalign, bus_err, e.inst, e.a, e.mis, e.be);
          end
        end
      end else if (misalign || bus_err) begin
        n_checks++;
        n_fail++;
        $display("FAIL orphan_flag: mis=%b be=%b without inst_valid, expected 0 0", misalign, bus_err);
      end
    end
  end

  initial begin
    int wcnt;
    #12 rst = 1'b0;
    step();
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_addr", inst_addr, 32'h0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_stall", {31'd0, stall_req}, 32'd0);

    // miss at 0x10, ack on 2nd WAIT cycle
    ce = 1'b1; addr = 32'h10;
    expect_resp(32'h34010005, 32'h10, 1'b0, 1'b0);
    #1 chk("miss_stall_idle", {31'd0, stall_req}, 32'd1);
    step();
    chk("miss_req_w1", {31'd0, mem_req}, 32'd1);
    chk("miss_mem_addr", mem_addr, 32'h10);
    chk("miss_stall_w1", {31'd0, stall_req}, 32'd1);
    step();
    mem_ack = 1'b1; mem_rdata = 32'h34010005;
    #1 chk("miss_req_w2", {31'd0, mem_req}, 32'd1);
    step();
    mem_ack = 1'b0;
    // back in IDLE with the same address: hit
    expect_resp(32'h34010005, 32'h10, 1'b0, 1'b0);
    #1 chk("hit_stall", {31'd0, stall_req}, 32'd0);
    chk("hit_mem_req", {31'd0, mem_req}, 32'd0);
    step();
    chk("hit_mem_req2", {31'd0, mem_req}, 32'd0);
    ce = 1'b0;
    step();

    // flushed miss at 0x20, ack 3 cycles after flush
    ce = 1'b1; addr = 32'h20;
    step();
    ce = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    #1 chk("drain_req", {31'd0, mem_req}, 32'd1);
    chk("drain_stall", {31'd0, stall_req}, 32'd1);
    step();
    step();
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    step();
    mem_ack = 1'b0;
    #1 chk("drain_req_drop", {31'd0, mem_req}, 32'd0);
    chk("drain_stall_drop", {31'd0, stall_req}, 32'd0);
    ce = 1'b1; addr = 32'h24;
    expect_resp(32'h11112222, 32'h24, 1'b0, 1'b0);
    step();
    chk("after_flush_mem_addr", mem_addr, 32'h24);
    mem_ack = 1'b1; mem_rdata = 32'h11112222;
    step();
    mem_ack = 1'b0; ce = 1'b0;
    step();

    // misaligned fetch
    ce = 1'b1; addr = 32'h6;
    expect_resp(32'h0, 32'h6, 1'b1, 1'b0);
    #1 chk("mis_stall", {31'd0, stall_req}, 32'd0);
    step();
    ce = 1'b0;
    chk("mis_mem_req", {31'd0, mem_req}, 32'd0);
    step();

    // timeout at 0x40
    ce = 1'b1; addr = 32'h40;
    expect_resp(32'h0, 32'h40, 1'b0, 1'b1);
    step();
    ce = 1'b0;
    wcnt = 0;
    while (mem_req && wcnt < 40) begin
      wcnt++;
      step();
    end
    chk("timeout_wait_cycles", wcnt, 16);
    ce = 1'b1; addr = 32'h40;
    #1 chk("timeout_refetch_miss", {31'd0, stall_req}, 32'd1);
    expect_resp(32'h00000055, 32'h40, 1'b0, 1'b0);
    step();
    chk("refetch_req", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h00000055;
    step();
    mem_ack = 1'b0; ce = 1'b0;
    step();

    // async reset in the middle of WAIT
    ce = 1'b1; addr = 32'h80;
    step();
    ce = 1'b0;
    step();
    #2 rst = 1'b1;
    #1 chk("arst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("arst_stall", {31'd0, stall_req}, 32'd0);
    chk("arst_valid", {31'd0, inst_valid}, 32'd0);
    #1 rst = 1'b0;
    step();
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    step();
    mem_ack = 1'b0;
    step();
    step();
    chk("scoreboard_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
